// File: rtl/serial_chunk_adder.sv
// ---------------------------------------------------------------------------
// serial_chunk_adder
//
// Multi-cycle adder/subtractor. It processes two WIDTH-bit operands CHUNK bits
// per clock through a CHUNK-bit ripple of full adders. The carry between
// chunks is held in a register. The block reports the unsigned carry (no
// borrow in subtract mode) and the signed two's-complement overflow.
//
// Parameters:
//   WIDTH    operand/result width, WIDTH >= 1
//   CHUNK    bits processed per cycle, WIDTH must be a multiple of CHUNK
//
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   rst_i    synchronous active-high reset, aborts any operation in flight
//   start_i  request a new operation, sampled only while idle
//   sub_i    0: x + y, 1: x - y (latched with the operands)
//   x_i      first operand, latched on an accepted start
//   y_i      second operand, latched on an accepted start
//   busy_o   high while an operation is in progress
//   done_o   one-cycle pulse when s_o/c_o/v_o are final
//   s_o      sum/difference modulo 2^WIDTH
//   c_o      final carry out (subtract: 1 = no borrow)
//   v_o      signed overflow
// ---------------------------------------------------------------------------
module serial_chunk_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] s_o,
   output logic             c_o,
   output logic             v_o
);

   localparam int unsigned N     = WIDTH / CHUNK;
   localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] KLast = KW'(N - 1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   // Operand registers shift right by CHUNK each RUN cycle, so the active
   // chunk is always in the low bits.
   logic [WIDTH-1:0] xr_q, xr_d;
   logic [WIDTH-1:0] yr_q, yr_d;
   logic             carry_q, carry_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             c_q, c_d;
   logic             v_q, v_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [CHUNK-1:0] chunk_a;
   logic [CHUNK-1:0] chunk_b;
   logic [CHUNK-1:0] chunk_sum;
   logic             chunk_cout;
   logic             chunk_cmsb;   // carry into the top bit of the chunk

   assign chunk_a = xr_q[CHUNK-1:0];
   assign chunk_b = yr_q[CHUNK-1:0];

   // CHUNK-bit ripple of full adders: the only combinational path per cycle.
   always_comb begin
      logic cy;
      chunk_sum  = '0;
      cy         = carry_q;
      chunk_cmsb = carry_q;
      for (int i = 0; i < int'(CHUNK); i++) begin
         chunk_sum[i] = chunk_a[i] ^ chunk_b[i] ^ cy;
         chunk_cmsb   = cy;
         cy           = (chunk_a[i] & chunk_b[i]) | (cy & (chunk_a[i] ^ chunk_b[i]));
      end
      chunk_cout = cy;
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      xr_d    = xr_q;
      yr_d    = yr_q;
      carry_d = carry_q;
      k_d     = k_q;
      s_d     = s_q;
      c_d     = c_q;
      v_d     = v_q;
      busy_d  = busy_q;
      done_d  = 1'b0;   // done only ever pulses on completion

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               xr_d    = x_i;
               // Subtraction as x + ~y + 1: the +1 enters as the initial carry.
               yr_d    = sub_i ? ~y_i : y_i;
               carry_d = sub_i;
               k_d     = '0;
               s_d     = '0;
               c_d     = 1'b0;
               v_d     = 1'b0;
               busy_d  = 1'b1;
               state_d = StRun;
            end
         end

         StRun: begin
            xr_d    = xr_q >> CHUNK;
            yr_d    = yr_q >> CHUNK;
            carry_d = chunk_cout;
            k_d     = k_q + KW'(1);
            for (int j = 0; j < int'(N); j++) begin
               if (k_q == KW'(j)) begin
                  s_d[j*CHUNK +: CHUNK] = chunk_sum;
               end
            end
            if (k_q == KLast) begin
               c_d     = chunk_cout;
               // The top bit of the last chunk is bit WIDTH-1 of the operands.
               v_d     = chunk_cmsb ^ chunk_cout;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               k_d     = '0;
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         xr_q    <= '0;
         yr_q    <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
         s_q     <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         xr_q    <= xr_d;
         yr_q    <= yr_d;
         carry_q <= carry_d;
         k_q     <= k_d;
         s_q     <= s_d;
         c_q     <= c_d;
         v_q     <= v_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign s_o    = s_q;
   assign c_o    = c_q;
   assign v_o    = v_q;

endmodule
